// File: rtl/signed_shift_pkg.sv
// Shared types and helpers for the signed shift-in / normalize paths.
package signed_shift_pkg;

   localparam int unsigned NORM_WIDTH  = 32;
   localparam int unsigned NORM_MANT_W = 8;

   // Width of a leading-zero / shift count for a word of the given width
   function automatic int unsigned shift_w(input int unsigned width);
      return $clog2(width);
   endfunction

   localparam int unsigned NORM_SHIFT_W = shift_w(NORM_WIDTH);

   typedef struct packed {
      logic                    sign;
      logic                    zero;
      logic                    sticky;
      logic [NORM_SHIFT_W-1:0] shift;
      logic [NORM_MANT_W-1:0]  mant;
   } norm_result_t;

endpackage

// File: rtl/signed_shift_normalize_lzc_tree.sv
// Combinational binary-tree leading-zero counter with all-zero flag.
module lzc_tree #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]         i_data,
   output logic [$clog2(WIDTH)-1:0] o_count,
   output logic                     o_all_zero
);

   localparam int unsigned LVLS = $clog2(WIDTH);
   localparam int unsigned P    = 1 << LVLS;

   // Left-justify into a power-of-two word; padding zeros sit below the LSB
   logic [P-1:0] w_pad;
   assign w_pad = P'(i_data) << (P - WIDTH);

   // Level 0 holds one leaf per bit (index 0 = MSB); each level merges pairs
   for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
      localparam int unsigned N = P >> l;
      logic [N-1:0]            z;
      logic [N-1:0][LVLS-1:0]  c;
      if (l == 0) begin : g_leaf
         for (genvar n = 0; n < N; n++) begin : g_n
            assign z[n] = ~w_pad[P-1-n];
            assign c[n] = '0;
         end
      end else begin : g_node
         for (genvar n = 0; n < N; n++) begin : g_n
            assign z[n] = g_lvl[l-1].z[2*n] & g_lvl[l-1].z[2*n+1];
            assign c[n] = g_lvl[l-1].z[2*n]
                        ? (LVLS'(1 << (l-1)) | g_lvl[l-1].c[2*n+1])
                        : g_lvl[l-1].c[2*n];
         end
      end
   end

   assign o_count    = g_lvl[LVLS].c[0];
   assign o_all_zero = g_lvl[LVLS].z[0];

endmodule

// File: rtl/signed_shift_normalize.sv
// Three-stage sign / leading-zero / normalize pipeline for signed accumulator words.
module signed_shift_normalize
   import signed_shift_pkg::*;
#(
   parameter  int unsigned WIDTH   = NORM_WIDTH,
   parameter  int unsigned MANT_W  = NORM_MANT_W,
   localparam int unsigned SHIFT_W = shift_w(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WIDTH-1:0]   s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_sign,
   output logic [SHIFT_W-1:0] m_shift,
   output logic [MANT_W-1:0]  m_mant,
   output logic               m_sticky,
   output logic               m_zero
);

   logic               w_adv;
   logic [WIDTH-1:0]   w_mag;
   logic [SHIFT_W-1:0] w_lzc;
   logic               w_all_zero;
   logic [WIDTH-1:0]   w_norm;

   logic               r_v1;
   logic               r_sign1;
   logic [WIDTH-1:0]   r_mag1;

   logic               r_v2;
   logic               r_sign2;
   logic               r_zero2;
   logic [WIDTH-1:0]   r_mag2;
   logic [SHIFT_W-1:0] r_lzc2;

   logic               r_v3;
   norm_result_t       r_out;

   // Whole pipe moves together whenever the output slot is free or draining
   assign w_adv   = ~r_v3 | m_ready;
   assign s_ready = w_adv;

   // Magnitude in WIDTH bits; the most negative value maps to 2^(WIDTH-1)
   assign w_mag = s_data[WIDTH-1] ? (~s_data + WIDTH'(1)) : s_data;

   lzc_tree #(.WIDTH(WIDTH)) u_lzc (
      .i_data     (r_mag1),
      .o_count    (w_lzc),
      .o_all_zero (w_all_zero)
   );

   assign w_norm = r_mag2 << r_lzc2;

   // Stage 1: sign and magnitude
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1    <= 1'b0;
         r_sign1 <= 1'b0;
         r_mag1  <= '0;
      end else if (w_adv) begin
         r_v1 <= s_valid;
         if (s_valid) begin
            r_sign1 <= s_data[WIDTH-1];
            r_mag1  <= w_mag;
         end
      end
   end

   // Stage 2: leading-zero count and zero detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2    <= 1'b0;
         r_sign2 <= 1'b0;
         r_zero2 <= 1'b0;
         r_mag2  <= '0;
         r_lzc2  <= '0;
      end else if (w_adv) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_sign2 <= r_sign1;
            r_zero2 <= w_all_zero;
            r_mag2  <= r_mag1;
            r_lzc2  <= w_lzc;
         end
      end
   end

   // Stage 3: normalize and register the result; payload only moves on valid data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3  <= 1'b0;
         r_out <= '0;
      end else if (w_adv) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_out.sign   <= r_sign2;
            r_out.zero   <= r_zero2;
            r_out.sticky <= |w_norm[WIDTH-MANT_W-1:0];
            r_out.shift  <= r_zero2 ? '0 : NORM_SHIFT_W'(r_lzc2);
            r_out.mant   <= NORM_MANT_W'(w_norm[WIDTH-1 -: MANT_W]);
         end
      end
   end

   assign m_valid  = r_v3;
   assign m_sign   = r_out.sign;
   assign m_zero   = r_out.zero;
   assign m_sticky = r_out.sticky;
   assign m_shift  = SHIFT_W'(r_out.shift);
   assign m_mant   = MANT_W'(r_out.mant);

endmodule

// File: tb/tb_signed_shift_normalize.sv
// Scoreboard bench for signed_shift_normalize (WIDTH=32, MANT_W=8).
module tb_signed_shift_normalize;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_sign;
   logic [4:0]  m_shift;
   logic [7:0]  m_mant;
   logic        m_sticky;
   logic        m_zero;

   logic [15:0] w_pay;
   logic [15:0] q[$];
   int          n_checks;
   int          n_err;
   logic        rnd_done;
   logic        prev_stall;
   logic [16:0] prev_obs;

   signed_shift_normalize #(.WIDTH(32), .MANT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_sign   (m_sign),
      .m_shift  (m_shift),
      .m_mant   (m_mant),
      .m_sticky (m_sticky),
      .m_zero   (m_zero)
   );

   assign w_pay = {m_sign, m_zero, m_sticky, m_shift, m_mant};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] pk(input logic s, input logic z, input logic st,
                                      input logic [4:0] sh, input logic [7:0] mt);
      return {s, z, st, sh, mt};
   endfunction

   // Reference: linear scan for leading zeros
   function automatic logic [15:0] model(input logic [31:0] d);
      logic [31:0] mag;
      logic [31:0] norm;
      int          lz;
      mag = d[31] ? (32'd0 - d) : d;
      if (mag == 32'd0) return pk(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
      lz = 0;
      while (!mag[31-lz]) lz++;
      norm = mag << lz;
      return pk(d[31], 1'b0, |norm[23:0], 5'(lz), norm[31:24]);
   endfunction

   // Drive one word, called and returning at posedge+1; queues expectation on acceptance
   task automatic send(input logic [31:0] d, input logic [15:0] e);
      logic ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int n = 0; n < 1000 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready;
         if (ok) q.push_back(e);
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 32'(ok), 32'd1);
      s_valid = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // After send() returns, count edges until m_valid rises
   task automatic check_latency(input string tag);
      int cnt;
      cnt = 1;
      while (!m_valid && cnt < 10) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk(tag, 32'(cnt), 32'd3);
   endtask

   // Output monitor: scoreboard pop on transfer, hold check during stall
   initial begin
      prev_stall = 1'b0;
      prev_obs   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) chk("hold", 32'({m_valid, w_pay}), 32'(prev_obs));
            if (m_valid && m_ready) begin
               if (q.size() == 0) chk("stray_result", 32'(m_valid), 32'd0);
               else chk("result", 32'(w_pay), 32'(q.pop_front()));
            end
            prev_stall = m_valid && !m_ready;
            prev_obs   = {m_valid, w_pay};
         end
      end
   end

   initial begin
      logic [31:0] d;
      n_checks = 0;
      n_err    = 0;
      rnd_done = 1'b0;
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      m_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mvalid", 32'(m_valid), 32'd0);
      chk("rst_payload", 32'(w_pay), 32'd0);
      rst_n = 1'b1;
      chk("rst_sready", 32'(s_ready), 32'd1);
      idle(1);

      // Directed vectors with hand-derived expectations
      send(32'h0000_0001, pk(1'b0, 1'b0, 1'b0, 5'd31, 8'h80));
      check_latency("latency_first");
      idle(3);
      send(32'hFFFF_FFFF, pk(1'b1, 1'b0, 1'b0, 5'd31, 8'h80));
      send(32'h8000_0000, pk(1'b1, 1'b0, 1'b0, 5'd0,  8'h80));
      send(32'h0001_2345, pk(1'b0, 1'b0, 1'b1, 5'd15, 8'h91));
      send(32'h0000_0000, pk(1'b0, 1'b1, 1'b0, 5'd0,  8'h00));
      idle(6);
      chk("directed_drained", 32'(q.size()), 32'd0);

      // Backpressure: six back-to-back words, output stalled five cycles
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               d = 32'h0000_0100 << (3 * i);
               if (i[0]) d = 32'd0 - d;
               send(d, model(d));
            end
         end
         begin
            m_ready = 1'b0;
            repeat (5) @(negedge clk);
            chk("s_ready_full", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      idle(6);
      chk("bp_drained", 32'(q.size()), 32'd0);

      // Reset with three results in flight
      m_ready = 1'b0;
      send(32'h0000_00FF, model(32'h0000_00FF));
      send(32'hFFFF_FF00, model(32'hFFFF_FF00));
      send(32'h0ABC_0000, model(32'h0ABC_0000));
      chk("pre_rst_mvalid", 32'(m_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mvalid", 32'(m_valid), 32'd0);
      chk("async_rst_payload", 32'(w_pay), 32'd0);
      q.delete();
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("release_sready", 32'(s_ready), 32'd1);
      idle(8);
      send(32'h0001_2345, pk(1'b0, 1'b0, 1'b1, 5'd15, 8'h91));
      check_latency("latency_after_rst");
      idle(3);

      // Random traffic with random backpressure against the reference model
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               case ($urandom_range(0, 3))
                  0:       d = $urandom;
                  1:       d = $urandom >> $urandom_range(0, 31);
                  2:       d = 32'd0 - ($urandom >> $urandom_range(0, 31));
                  default: d = (i % 7 == 0) ? 32'h8000_0000 : ((i % 5 == 0) ? 32'd0 : $urandom >> $urandom_range(20, 31));
               endcase
               send(d, model(d));
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join

      for (int i = 0; i < 100 && q.size() != 0; i++) idle(1);
      chk("final_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
